// File: rtl/cdc_handshake_tx.sv
// Source side of a toggle request/acknowledge multi-bit clock-domain crossing.
// Captures one word, holds it on xfer_data, toggles xfer_req and waits for the echoed ack.
module cdc_handshake_tx #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] xfer_data,
  output logic              xfer_req,
  input  logic              ack_sync,
  output logic              done_pulse,
  output logic              busy,
  output logic              timeout_err,
  output logic              protocol_err,
  input  logic              err_clr
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] xfer_data_q, xfer_data_d;
  logic              xfer_req_q, xfer_req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              protocol_err_q, protocol_err_d;

  logic              accept_s;
  logic              ack_match_s;
  logic              timeout_hit_s;
  logic              spurious_ack_s;

  assign accept_s    = in_valid & in_ready;
  assign ack_match_s = (ack_sync == xfer_req_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack_match_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decoded only from the state register
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_SETUP, ST_WAIT: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Crossing bus, request toggle, timeout counter and completion pulse
  always_comb begin
    xfer_data_d   = xfer_data_q;
    xfer_req_d    = xfer_req_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          xfer_data_d = in_data;
          cnt_d       = CNT_LOAD;
        end else begin
          xfer_data_d = xfer_data_q;
          cnt_d       = cnt_q;
        end
      end
      ST_SETUP: begin
        // Data has had a full cycle to settle before the request edge
        xfer_req_d = ~xfer_req_q;
      end
      ST_WAIT: begin
        if (ack_match_s) begin
          done_d = 1'b1;
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          timeout_hit_s = 1'b1;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  // Sticky error flags; a set condition beats a simultaneous clear
  always_comb begin
    spurious_ack_s = (state_q == ST_IDLE) && !ack_match_s;

    if (timeout_hit_s) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end

    if (spurious_ack_s) begin
      protocol_err_d = 1'b1;
    end else if (err_clr) begin
      protocol_err_d = 1'b0;
    end else begin
      protocol_err_d = protocol_err_q;
    end
  end

  // Datapath and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_data_q    <= {DATA_W{1'b0}};
      xfer_req_q     <= 1'b0;
      cnt_q          <= CNT_ZERO;
      done_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      xfer_data_q    <= xfer_data_d;
      xfer_req_q     <= xfer_req_d;
      cnt_q          <= cnt_d;
      done_q         <= done_d;
      timeout_err_q  <= timeout_err_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign xfer_data    = xfer_data_q;
  assign xfer_req     = xfer_req_q;
  assign done_pulse   = done_q;
  assign timeout_err  = timeout_err_q;
  assign protocol_err = protocol_err_q;

endmodule
